// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM command queue front-end.
package sram_pkg;

    localparam int ADDR_W           = 15;
    localparam int DATA_W           = 16;
    localparam int CMDQ_DEPTH       = 4;
    localparam int CMDQ_ACK_TIMEOUT = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } cmdq_state_t;

endpackage

// File: rtl/sram_cmd_fifo.sv
// Synchronous FIFO of SRAM commands; push is refused when full even if a pop
// happens in the same cycle. Head entry is visible combinationally.
module sram_cmd_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  sram_cmd_t        i_data,
    input  logic             i_pop,
    output sram_cmd_t        o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    sram_cmd_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/sram_cmd_queue.sv
// CPU-side command queue for the SRAM controller: buffers commands, replays them as
// single-cycle req pulses, and returns read data through a one-entry response slot.
module sram_cmd_queue
    import sram_pkg::*;
#(
    parameter int DEPTH       = CMDQ_DEPTH,
    parameter int ACK_TIMEOUT = CMDQ_ACK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   ctrl_read_req,
    output logic                   ctrl_write_req,
    output logic [ADDR_W-1:0]      ctrl_address,
    output logic [DATA_W-1:0]      ctrl_write_data,
    input  logic [DATA_W-1:0]      ctrl_read_data,
    input  logic                   ctrl_ready,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   ack_err,
    output logic [1:0]             dbg_state
);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready, and
    // rsp_valid/rsp_data are held unchanged until that edge.

    cmdq_state_t       r_state;
    logic              r_read_req;
    logic              r_write_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic [TMR_W-1:0]  r_timer;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_ack_err;

    sram_cmd_t         w_cmd;
    sram_cmd_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;

    assign w_cmd.we    = cmd_we;
    assign w_cmd.addr  = cmd_addr;
    assign w_cmd.wdata = cmd_wdata;

    sram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_data  (w_cmd),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    // Reads wait while the response slot is occupied; writes never need it.
    assign w_issue = (r_state == IDLE) && !w_empty && ctrl_ready
                     && (w_head.we || !r_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ack_err   <= 1'b0;
        end else begin
            if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_addr      <= w_head.addr;
                        r_wdata     <= w_head.wdata;
                        r_is_write  <= w_head.we;
                        r_write_req <= w_head.we;
                        r_read_req  <= !w_head.we;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_write_req <= 1'b0;
                    r_read_req  <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // A controller that never goes busy loses the command and flags it.
                    if (!ctrl_ready) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                        r_ack_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ctrl_ready) begin
                        if (!r_is_write) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= ctrl_read_data;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready       = !w_full;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign ctrl_read_req   = r_read_req;
    assign ctrl_write_req  = r_write_req;
    assign ctrl_address    = r_addr;
    assign ctrl_write_data = r_wdata;
    assign ack_err         = r_ack_err;
    assign dbg_state       = r_state;

endmodule
